load_store_unit: RTL and testbench

- Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register.
- Takes the memory-stage address, store data and control, then runs a ready-handshaked access on the data-memory bus.
- Stalls the pipeline while the access is in flight.
- Returns an aligned, sign/zero-extended read_data_M for the MEM/WB register to capture.

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues one ready-handshaked data-memory access
// per load/store, stalls the pipe while it is outstanding and returns the
// aligned, extended load result to the MEM/WB register.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   MemRead_M/MemWrite_M load / store request in the memory stage
//   funct3_M            RV32I access size and signedness
//   ALUResult_M         effective byte address
//   write_data_M        store data (rs2)
//   read_data_M         extended load result, held between accesses
//   stall_M             freeze upstream stages, hold MEM/WB
//   misalign_M          one-cycle pulse: misaligned access dropped
//   bus_err_M           one-cycle pulse: illegal op or bus timeout
//   mem_*               data-memory bus (word address, byte strobes)
module load_store_unit #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead_M,
   input  logic              MemWrite_M,
   input  logic [2:0]        funct3_M,
   input  logic [ADDR_W-1:0] ALUResult_M,
   input  logic [31:0]       write_data_M,
   output logic [31:0]       read_data_M,
   output logic              stall_M,
   output logic              misalign_M,
   output logic              bus_err_M,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [2:0]         l_funct3, l_funct3_nxt;
   logic [1:0]         l_off, l_off_nxt;
   logic [31:0]        read_data_nxt, mem_wdata_nxt;
   logic [ADDR_W-1:0]  mem_addr_nxt;
   logic [3:0]         mem_wstrb_nxt;
   logic               misalign_nxt, bus_err_nxt, mem_req_nxt, mem_we_nxt;

   logic               acc_c, both_c, illegal_c, misal_c, go_c;
   logic [1:0]         off_c;
   logic [31:0]        lane_c, load_ext_c, st_wdata_c;
   logic [3:0]         st_wstrb_c;

   // Request decode and alignment checks
   always_comb begin
      off_c     = ALUResult_M[1:0];
      acc_c     = MemRead_M ^ MemWrite_M;
      both_c    = MemRead_M & MemWrite_M;
      illegal_c = (funct3_M == 3'b011) || (funct3_M == 3'b110) || (funct3_M == 3'b111);
      misal_c   = ((funct3_M[1:0] == 2'b01) && off_c[0]) ||
                  ((funct3_M[1:0] == 2'b10) && (off_c != 2'b00));
      go_c      = (state == IDLE) && acc_c && !illegal_c && !misal_c;
   end

   // Upstream freezes in the issue cycle and through every BUSY cycle
   assign stall_M = go_c || (state == BUSY);

   // Store lane replication and byte strobes
   always_comb begin
      st_wdata_c = write_data_M;
      st_wstrb_c = 4'b1111;
      case (funct3_M[1:0])
         2'b00: begin
            st_wdata_c = {4{write_data_M[7:0]}};
            st_wstrb_c = 4'b0001 << off_c;
         end
         2'b01: begin
            st_wdata_c = {2{write_data_M[15:0]}};
            st_wstrb_c = 4'b0011 << off_c;
         end
         default: ;
      endcase
   end

   // Load lane extraction from the latched offset and size
   always_comb begin
      lane_c = mem_rdata >> {l_off, 3'b000};
      case (l_funct3)
         3'b000:  load_ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
         3'b001:  load_ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
         3'b100:  load_ext_c = {24'h0, lane_c[7:0]};
         3'b101:  load_ext_c = {16'h0, lane_c[15:0]};
         default: load_ext_c = lane_c;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      l_funct3_nxt  = l_funct3;
      l_off_nxt     = l_off;
      read_data_nxt = read_data_M;
      misalign_nxt  = 1'b0;
      bus_err_nxt   = 1'b0;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_wstrb_nxt = mem_wstrb;
      case (state)
         IDLE: begin
            if (both_c || (acc_c && illegal_c)) begin
               bus_err_nxt = 1'b1;
            end else if (acc_c && misal_c) begin
               misalign_nxt  = 1'b1;
               read_data_nxt = 32'h0;
            end else if (acc_c) begin
               l_funct3_nxt  = funct3_M;
               l_off_nxt     = off_c;
               cnt_nxt       = '0;
               mem_req_nxt   = 1'b1;
               mem_we_nxt    = MemWrite_M;
               mem_addr_nxt  = {ALUResult_M[ADDR_W-1:2], 2'b00};
               mem_wdata_nxt = MemWrite_M ? st_wdata_c : 32'h0;
               mem_wstrb_nxt = MemWrite_M ? st_wstrb_c : 4'b0000;
               state_nxt     = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               mem_req_nxt   = 1'b0;
               mem_we_nxt    = 1'b0;
               mem_wstrb_nxt = 4'b0000;
               if (!mem_we) read_data_nxt = load_ext_c;
               state_nxt     = DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               // cnt counts completed BUSY cycles, so this is the TIMEOUT-th one
               mem_req_nxt   = 1'b0;
               mem_we_nxt    = 1'b0;
               mem_wstrb_nxt = 4'b0000;
               bus_err_nxt   = 1'b1;
               read_data_nxt = 32'h0;
               state_nxt     = DONE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         l_funct3    <= 3'b000;
         l_off       <= 2'b00;
         read_data_M <= 32'h0;
         misalign_M  <= 1'b0;
         bus_err_M   <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 32'h0;
         mem_wstrb   <= 4'b0000;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         l_funct3    <= l_funct3_nxt;
         l_off       <= l_off_nxt;
         read_data_M <= read_data_nxt;
         misalign_M  <= misalign_nxt;
         bus_err_M   <= bus_err_nxt;
         mem_req     <= mem_req_nxt;
         mem_we      <= mem_we_nxt;
         mem_addr    <= mem_addr_nxt;
         mem_wdata   <= mem_wdata_nxt;
         mem_wstrb   <= mem_wstrb_nxt;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a decoupled scoreboard: the driver
// queues expected bus requests and completions, a negedge monitor pops and
// compares whenever the DUT raises mem_req, completes, or pulses an error.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead_M, MemWrite_M;
   logic [2:0]  funct3_M;
   logic [31:0] ALUResult_M, write_data_M;
   logic [31:0] read_data_M;
   logic        stall_M, misalign_M, bus_err_M;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wd; } req_t;
   typedef struct { logic [31:0] rd; logic mis; logic err; int stall; } cpl_t;
   req_t req_q[$];
   cpl_t cpl_q[$];

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .funct3_M(funct3_M),
      .ALUResult_M(ALUResult_M), .write_data_M(write_data_M),
      .read_data_M(read_data_M), .stall_M(stall_M),
      .misalign_M(misalign_M), .bus_err_M(bus_err_M),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_req(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] wd);
      req_t r;
      r.addr = a; r.we = we; r.strb = s; r.wd = wd;
      req_q.push_back(r);
   endtask

   task automatic exp_cpl(input logic [31:0] rd, input logic mis, input logic err, input int stall);
      cpl_t c;
      c.rd = rd; c.mis = mis; c.err = err; c.stall = stall;
      cpl_q.push_back(c);
   endtask

   // Monitor: request on mem_req rise, completion on mem_req fall or error pulse
   logic prev_req;
   int   stall_run = 0;
   always @(negedge clk) begin
      req_t r;
      cpl_t c;
      if (prev_req === 1'b0 && mem_req === 1'b1) begin
         if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got addr 0x%08h expected no request", mem_addr);
         end else begin
            r = req_q.pop_front();
            chk("req_addr",  mem_addr,        r.addr);
            chk("req_we",    32'(mem_we),     32'(r.we));
            chk("req_wstrb", 32'(mem_wstrb),  32'(r.strb));
            chk("req_wdata", mem_wdata,       r.wd);
         end
      end
      if (misalign_M === 1'b1 || bus_err_M === 1'b1 || (prev_req === 1'b1 && mem_req === 1'b0)) begin
         if (cpl_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cpl_unexpected: got rd 0x%08h mis %b err %b expected no event",
                     read_data_M, misalign_M, bus_err_M);
         end else begin
            c = cpl_q.pop_front();
            chk("read_data", read_data_M,      c.rd);
            chk("misalign",  32'(misalign_M),  32'(c.mis));
            chk("bus_err",   32'(bus_err_M),   32'(c.err));
            if (c.stall >= 0) chk("stall_cycles", 32'(stall_run), 32'(c.stall));
         end
      end
      stall_run = (stall_M === 1'b1) ? stall_run + 1 : 0;
      prev_req  = mem_req;
   end

   // Present one memory-stage op; mem_ready rises in BUSY cycle dly (0 = never)
   task automatic op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int dly, input logic [31:0] rdata);
      bit left = 1'b0;
      int busy = 0;
      MemRead_M = rd; MemWrite_M = wr; funct3_M = f3; ALUResult_M = a; write_data_M = wd;
      mem_ready = 1'b0; mem_rdata = ~rdata;
      for (int c = 0; c < 40 && !left; c++) begin
         @(posedge clk); #1;
         if (mem_req !== 1'b1) left = 1'b1;
         else begin
            busy++;
            mem_ready = (dly > 0 && busy >= dly);
            mem_rdata = mem_ready ? rdata : ~rdata;
         end
      end
      MemRead_M = 1'b0; MemWrite_M = 1'b0; mem_ready = 1'b0;
      if (!left) begin
         checks++; errors++;
         $display("FAIL op_bound: got mem_req still high after 40 cycles expected completion");
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0; funct3_M = 3'b000;
      ALUResult_M = 32'h0; write_data_M = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req",   32'(mem_req),    32'h0);
      chk("rst_mem_we",    32'(mem_we),     32'h0);
      chk("rst_mem_wstrb", 32'(mem_wstrb),  32'h0);
      chk("rst_mem_addr",  mem_addr,        32'h0);
      chk("rst_mem_wdata", mem_wdata,       32'h0);
      chk("rst_read_data", read_data_M,     32'h0);
      chk("rst_misalign",  32'(misalign_M), 32'h0);
      chk("rst_bus_err",   32'(bus_err_M),  32'h0);
      chk("rst_stall",     32'(stall_M),    32'h0);
      reset = 1'b1;
      @(posedge clk); #1;

      // LW, ready in third BUSY cycle
      exp_req(32'h100, 1'b0, 4'b0000, 32'h0); exp_cpl(32'hDEADBEEF, 1'b0, 1'b0, 4);
      op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
      // LB / LBU / LH / LHU on 0x80FF0000
      exp_req(32'h100, 1'b0, 4'b0000, 32'h0); exp_cpl(32'hFFFFFF80, 1'b0, 1'b0, 2);
      op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0000);
      exp_req(32'h100, 1'b0, 4'b0000, 32'h0); exp_cpl(32'h00000080, 1'b0, 1'b0, 2);
      op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0000);
      exp_req(32'h100, 1'b0, 4'b0000, 32'h0); exp_cpl(32'hFFFF80FF, 1'b0, 1'b0, 2);
      op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF0000);
      exp_req(32'h100, 1'b0, 4'b0000, 32'h0); exp_cpl(32'h000080FF, 1'b0, 1'b0, 2);
      op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80FF0000);
      // Stores leave read_data_M unchanged
      exp_req(32'h200, 1'b1, 4'b0010, 32'h78787878); exp_cpl(32'h000080FF, 1'b0, 1'b0, 2);
      op(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 1, 32'h0);
      exp_req(32'h200, 1'b1, 4'b1100, 32'h56785678); exp_cpl(32'h000080FF, 1'b0, 1'b0, 2);
      op(1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 1, 32'h0);
      exp_req(32'h204, 1'b1, 4'b1111, 32'hA5A55A5A); exp_cpl(32'h000080FF, 1'b0, 1'b0, 3);
      op(1'b0, 1'b1, 3'b010, 32'h204, 32'hA5A55A5A, 2, 32'h0);
      // Misaligned LW, then a load to make read_data_M nonzero
      exp_cpl(32'h0, 1'b1, 1'b0, 0);
      op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
      exp_req(32'h104, 1'b0, 4'b0000, 32'h0); exp_cpl(32'h11223344, 1'b0, 1'b0, 2);
      op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h11223344);
      // Read and write together, then illegal funct3: no access, data held
      exp_cpl(32'h11223344, 1'b0, 1'b1, 0);
      op(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 1, 32'h0);
      exp_cpl(32'h11223344, 1'b0, 1'b1, 0);
      op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
      // Timeout after 4 BUSY cycles
      exp_req(32'h108, 1'b0, 4'b0000, 32'h0); exp_cpl(32'h0, 1'b0, 1'b1, 5);
      op(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 0, 32'h0);
      // Back-to-back loads
      exp_req(32'h10C, 1'b0, 4'b0000, 32'h0); exp_cpl(32'hCAFEF00D, 1'b0, 1'b0, 2);
      op(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 1, 32'hCAFEF00D);
      exp_req(32'h10C, 1'b0, 4'b0000, 32'h0); exp_cpl(32'h00008001, 1'b0, 1'b0, 2);
      op(1'b1, 1'b0, 3'b101, 32'h10E, 32'h0, 1, 32'h80010000);

      // Reset during BUSY: request drops, read data cleared, late ready ignored
      exp_req(32'h300, 1'b0, 4'b0000, 32'h0); exp_cpl(32'h0, 1'b0, 1'b0, -1);
      MemRead_M = 1'b1; funct3_M = 3'b010; ALUResult_M = 32'h300;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0; MemRead_M = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      chk("post_rst_mem_req", 32'(mem_req), 32'h0);
      chk("post_rst_stall",   32'(stall_M), 32'h0);
      chk("post_rst_rdata",   read_data_M,  32'h0);
      mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
      repeat (3) @(posedge clk);
      #1;
      mem_ready = 1'b0;
      chk("late_ready_rdata", read_data_M, 32'h0);

      // Misaligned SH clears read data; then a final word load
      exp_cpl(32'h0, 1'b1, 1'b0, 0);
      op(1'b0, 1'b1, 3'b001, 32'h203, 32'h12345678, 1, 32'h0);
      exp_req(32'h110, 1'b0, 4'b0000, 32'h0); exp_cpl(32'h00007FFF, 1'b0, 1'b0, 2);
      op(1'b1, 1'b0, 3'b010, 32'h110, 32'h0, 1, 32'h00007FFF);

      repeat (4) @(posedge clk);
      #1;
      chk("req_q_left", 32'(req_q.size()), 32'h0);
      chk("cpl_q_left", 32'(cpl_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
